bus_owner_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit registered bus between four requesters in the pipeline datapath. It produces one-hot grant lines that drive the enable inputs of the per-requester bus-driver registers. It also registers the selected requester's data onto a common bus with a valid flag. It enforces a one-cycle turnaround between owners and a maximum hold time, so that no requester can starve the others.

---
 rtl/bus_owner_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_owner_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for a shared registered bus.
// One-cycle turnaround between owners and a bounded hold time.
module bus_owner_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [3:0]         done,
  input  logic [4*WIDTH-1:0] bus_in,
  output logic [3:0]         grant,
  output logic [1:0]         owner,
  output logic [WIDTH-1:0]   bus_out,
  output logic               bus_valid,
  output logic               timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;

  logic       found;
  logic [1:0] win;
  logic [1:0] idx;
  logic       own_done;
  logic       own_req;
  logic       at_last;

  // Rotating priority search starting at ptr
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign own_done = done[owner_q];
  assign own_req  = req[owner_q];
  assign at_last  = (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE, TURN: begin
        if (found) begin
          state_d = OWN;
          grant_d = 4'b0001 << win;
          owner_d = win;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      OWN: begin
        if (own_done || !own_req || at_last) begin
          state_d = TURN;
          grant_d = '0;
          ptr_d   = owner_q + 2'd1;
          tmo_d   = !own_done && own_req && at_last;
        end else begin
          hold_d  = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Data follows grant by one cycle, including the release cycle
  always_comb begin
    valid_d = (state_q == OWN);
    bus_d   = bus_q;
    if (state_q == OWN) begin
      bus_d = bus_in[int'(owner_q)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      bus_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign bus_out   = bus_q;
  assign bus_valid = valid_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Bench for bus_owner_arbiter: directed scenarios plus random
// traffic checked against an ownership-level reference model.
module tb_bus_owner_arbiter;

  localparam int W  = 8;
  localparam int MH = 4;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [3:0]   done;
  logic [4*W-1:0] bus_in;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic [W-1:0] bus_out;
  logic         bus_valid;
  logic         timeout;

  int total = 0;
  int bad   = 0;

  int m_own;
  int m_held;
  int m_ptr;
  int m_last;
  logic [3:0]   e_grant;
  logic [1:0]   e_owner;
  logic [W-1:0] e_bus;
  logic         e_valid;
  logic         e_to;

  logic [3:0] rot [8];

  bus_owner_arbiter #(
    .WIDTH(W),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .done(done),
    .bus_in(bus_in),
    .grant(grant),
    .owner(owner),
    .bus_out(bus_out),
    .bus_valid(bus_valid),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own   = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_last  = 0;
    e_grant = '0;
    e_owner = '0;
    e_bus   = '0;
    e_valid = 1'b0;
    e_to    = 1'b0;
  endtask

  // Ownership view: an owner holds for up to MH cycles, then the
  // bus is free for one cycle before anybody can own it again.
  task automatic model_edge();
    int w;
    e_valid = (m_own >= 0);
    if (m_own >= 0) e_bus = bus_in[m_own*W +: W];
    e_to = 1'b0;
    if (m_own >= 0) begin
      m_held++;
      if (done[m_own] || !req[m_own] || m_held == MH) begin
        e_to  = !done[m_own] && req[m_own];
        m_ptr = (m_own + 1) % 4;
        m_own = -1;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        w = (m_ptr + k) % 4;
        if (m_own < 0 && req[w]) begin
          m_own  = w;
          m_held = 0;
          m_last = w;
        end
      end
    end
    e_grant = (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
    e_owner = 2'(m_last);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
    chk({tag, ".owner"}, 32'(owner), 32'(e_owner));
    chk({tag, ".valid"}, 32'(bus_valid), 32'(e_valid));
    chk({tag, ".bus"}, 32'(bus_out), 32'(e_bus));
    chk({tag, ".tmo"}, 32'(timeout), 32'(e_to));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rot[0] = 4'b0000; rot[1] = 4'b0010;
    rot[2] = 4'b0000; rot[3] = 4'b0100;
    rot[4] = 4'b0000; rot[5] = 4'b1000;
    rot[6] = 4'b0000; rot[7] = 4'b0001;

    reset  = 1'b1;
    req    = 4'b1111;
    done   = 4'b0000;
    bus_in = 32'h4433_2211;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.grant", 32'(grant), 32'h0);
    chk("rst.valid", 32'(bus_valid), 32'h0);
    chk("rst.bus", 32'(bus_out), 32'h0);
    chk("rst.tmo", 32'(timeout), 32'h0);
    chk("rst.owner", 32'(owner), 32'h0);
    reset = 1'b0;
    step("first");
    chk("first.g", 32'(grant), 32'h1);

    // rotation with done in first cycle of each ownership
    for (int i = 0; i < 8; i++) begin
      done = e_grant;
      step("rot");
      chk("rot.seq", 32'(grant), 32'(rot[i]));
    end
    done = e_grant;
    req  = 4'b0000;
    step("rot_end");
    done = 4'b0000;
    step("idle");

    // single transfer from requester 2
    bus_in = 32'h00A5_0000;
    req    = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step("single");
      chk("single.g", 32'(grant), 32'h4);
    end
    done = 4'b0100;
    req  = 4'b0000;
    step("single_rel");
    chk("single.bus", 32'(bus_out), 32'hA5);
    chk("single.v", 32'(bus_valid), 32'h1);
    done = 4'b0000;
    step("single_idle");
    chk("single.v0", 32'(bus_valid), 32'h0);

    // ptr now 3: requester 3 beats 0
    req = 4'b1001;
    step("prio");
    chk("prio.g", 32'(grant), 32'h8);
    step("hold2");
    step("hold3");
    step("hold4");
    done = 4'b1000;
    step("done_tmo");
    chk("done_tmo.t", 32'(timeout), 32'h0);
    done = 4'b0000;
    step("after");
    chk("after.g", 32'(grant), 32'h1);
    req = 4'b0000;
    repeat (3) step("drain");

    // sole requester forced off by the hold counter
    req = 4'b0010;
    step("tmo_first");
    for (int i = 0; i < 10; i++) begin
      step("tmo");
      chk("tmo.per", 32'(timeout), (i % 5 == 3) ? 32'h1 : 32'h0);
      chk("tmo.g", 32'(grant), (i % 5 == 3) ? 32'h0 : 32'h2);
    end
    req = 4'b0000;
    repeat (3) step("drain2");

    // asynchronous reset during second grant cycle
    req = 4'b0100;
    step("mr1");
    step("mr2");
    reset = 1'b1;
    #1;
    chk("mr.grant", 32'(grant), 32'h0);
    chk("mr.valid", 32'(bus_valid), 32'h0);
    chk("mr.owner", 32'(owner), 32'h0);
    model_reset();
    #2;
    reset = 1'b0;
    req   = 4'b0101;
    step("mr_after");
    chk("mr_after.g", 32'(grant), 32'h1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      bus_in = $urandom;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
